// File: rtl/sliding_window_nxm_stream.sv
// Streaming 3x3 window generator over raster-order pixels with line buffers,
// frame position tracking and selectable border handling (valid/zero/replicate).
module sliding_window_nxm_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int MODE   = 1,
    localparam int XW    = $clog2(IMG_W),
    localparam int YW    = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] P1,
    output logic [DATA_W-1:0] P2,
    output logic [DATA_W-1:0] P3,
    output logic [DATA_W-1:0] P4,
    output logic [DATA_W-1:0] P5,
    output logic [DATA_W-1:0] P6,
    output logic [DATA_W-1:0] P7,
    output logic [DATA_W-1:0] P8,
    output logic [DATA_W-1:0] P9,
    output logic [XW-1:0]     out_x,
    output logic [YW-1:0]     out_y,
    output logic              out_eof
);

    localparam bit REPL = (MODE == 2);

    typedef logic [DATA_W-1:0] pix_t;

    logic [XW-1:0] x_q, x_d, px;
    logic [YW-1:0] y_q, y_d, py;
    logic          accept;
    logic          last_x;
    logic          last_y;
    logic          win_vld;

    pix_t lb1 [IMG_W];
    pix_t lb2 [IMG_W];
    pix_t c1_q [3];
    pix_t c2_q [3];
    pix_t raw  [3][3];
    pix_t colf [3][3];
    pix_t win  [3][3];

    logic          out_valid_q;
    pix_t          p_q [9];
    logic [XW-1:0] out_x_q;
    logic [YW-1:0] out_y_q;
    logic          out_eof_q;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // in_sof relocates the current pixel to the frame origin
    always_comb begin
        px      = in_sof ? '0 : x_q;
        py      = in_sof ? '0 : y_q;
        last_x  = (px == XW'(IMG_W - 1));
        last_y  = (py == YW'(IMG_H - 1));
        win_vld = (MODE == 0) ? ((px >= XW'(2)) && (py >= YW'(2))) : 1'b1;
        x_d     = last_x ? '0 : px + 1'b1;
        y_d     = py;
        if (last_x) begin
            y_d = last_y ? '0 : py + 1'b1;
        end
    end

    // Rows: 0 = y-2, 1 = y-1, 2 = y.  Cols: 0 = x-2, 1 = x-1, 2 = x.
    always_comb begin
        raw[0][0] = c2_q[0];
        raw[0][1] = c1_q[0];
        raw[0][2] = lb2[px];
        raw[1][0] = c2_q[1];
        raw[1][1] = c1_q[1];
        raw[1][2] = lb1[px];
        raw[2][0] = c2_q[2];
        raw[2][1] = c1_q[2];
        raw[2][2] = in_data;
        for (int r = 0; r < 3; r++) begin
            colf[r][0] = raw[r][0];
            colf[r][1] = raw[r][1];
            colf[r][2] = raw[r][2];
            if (px == '0) begin
                colf[r][0] = REPL ? raw[r][2] : '0;
                colf[r][1] = REPL ? raw[r][2] : '0;
            end else if (px == XW'(1)) begin
                colf[r][0] = REPL ? raw[r][1] : '0;
            end
        end
        for (int c = 0; c < 3; c++) begin
            win[0][c] = colf[0][c];
            win[1][c] = colf[1][c];
            win[2][c] = colf[2][c];
            if (py == '0) begin
                win[0][c] = REPL ? colf[2][c] : '0;
                win[1][c] = REPL ? colf[2][c] : '0;
            end else if (py == YW'(1)) begin
                win[0][c] = REPL ? colf[1][c] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_eof_q   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                c1_q[r] <= '0;
                c2_q[r] <= '0;
            end
            for (int k = 0; k < 9; k++) begin
                p_q[k] <= '0;
            end
        end else begin
            if (accept) begin
                x_q <= x_d;
                y_q <= y_d;
                for (int r = 0; r < 3; r++) begin
                    c1_q[r] <= raw[r][2];
                    c2_q[r] <= c1_q[r];
                end
            end
            if (in_ready) begin
                out_valid_q <= accept & win_vld;
                if (accept && win_vld) begin
                    for (int k = 0; k < 9; k++) begin
                        p_q[k] <= win[k / 3][k % 3];
                    end
                    out_x_q   <= px;
                    out_y_q   <= py;
                    out_eof_q <= last_x & last_y;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[px] <= in_data;
            lb2[px] <= lb1[px];
        end
    end

    assign out_valid = out_valid_q;
    assign P1        = p_q[0];
    assign P2        = p_q[1];
    assign P3        = p_q[2];
    assign P4        = p_q[3];
    assign P5        = p_q[4];
    assign P6        = p_q[5];
    assign P7        = p_q[6];
    assign P8        = p_q[7];
    assign P9        = p_q[8];
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_sliding_window_nxm_stream.sv
// Bench for the 3x3 window generator: one 4x4 instance per border mode,
// directed frames plus random traffic checked against a frame-image model.
module tb_sliding_window_nxm_stream;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sof;
    logic       in_valid  [3];
    logic       out_ready [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       out_eof   [3];
    logic [7:0] p         [3][9];
    logic [1:0] ox        [3];
    logic [1:0] oy        [3];

    int total = 0;
    int bad   = 0;

    logic [71:0] expq [3][$];
    logic [4:0]  expc [3][$];
    int          img  [3][H][W];
    int          mx   [3];
    int          my   [3];
    logic [71:0] obs     [3][H][W];
    logic        obs_eof [3][H][W];
    int          win_cnt [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sliding_window_nxm_stream #(
            .DATA_W(8), .IMG_W(W), .IMG_H(H), .MODE(g)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_sof   (in_sof),
            .in_data  (in_data),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .P1       (p[g][0]),
            .P2       (p[g][1]),
            .P3       (p[g][2]),
            .P4       (p[g][3]),
            .P5       (p[g][4]),
            .P6       (p[g][5]),
            .P7       (p[g][6]),
            .P8       (p[g][7]),
            .P9       (p[g][8]),
            .out_x    (ox[g]),
            .out_y    (oy[g]),
            .out_eof  (out_eof[g])
        );
    end

    function automatic logic [71:0] win_of(input int m);
        logic [71:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) w = {w[63:0], p[m][k]};
        return w;
    endfunction

    function automatic logic [7:0] pix(input int i);
        return 8'(16 * (i / W + 1) + (i % W + 1));
    endfunction

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Window = 3x3 neighbourhood of the frame image ending at the new pixel
    task automatic model_accept(input int m, input logic [7:0] d,
                                input logic sof);
        logic [71:0] w;
        int r, c;
        if (sof) begin
            mx[m] = 0;
            my[m] = 0;
        end
        img[m][my[m]][mx[m]] = d;
        if (m != 0 || (mx[m] >= 2 && my[m] >= 2)) begin
            w = '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r = my[m] - 2 + i;
                    c = mx[m] - 2 + j;
                    if (m == 2) begin
                        if (r < 0) r = 0;
                        if (c < 0) c = 0;
                    end
                    w = {w[63:0], (r < 0 || c < 0) ? 8'h00 : 8'(img[m][r][c])};
                end
            end
            expq[m].push_back(w);
            expc[m].push_back({2'(mx[m]), 2'(my[m]),
                               (mx[m] == W - 1 && my[m] == H - 1)});
        end
        if (mx[m] == W - 1) begin
            mx[m] = 0;
            my[m] = (my[m] == H - 1) ? 0 : my[m] + 1;
        end else begin
            mx[m]++;
        end
    endtask

    task automatic drive(input int m, input logic [7:0] d, input logic sof,
                         input bit rnd);
        int  n;
        bit  rdy;
        n = 0;
        rdy = 1'b0;
        if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
                out_ready[m] = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
        end
        in_valid[m] = 1'b1;
        in_data     = d;
        in_sof      = sof;
        while (1) begin
            @(negedge clk);
            rdy = in_ready[m];
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 50) break;
            if (rnd) out_ready[m] = ($urandom_range(0, 1) != 0);
        end
        check("accept_timeout", rdy, 1'b1);
        if (rdy) model_accept(m, d, sof);
        in_valid[m] = 1'b0;
        in_sof      = 1'b0;
        if (rnd) out_ready[m] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        for (int m = 0; m < 3; m++) begin
            win_cnt[m] = 0;
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    obs[m][y][x]     = 'x;
                    obs_eof[m][y][x] = 1'bx;
                end
            end
        end
    endtask

    task automatic run_frame(input int m);
        for (int i = 0; i < W * H; i++) drive(m, pix(i), 1'b0, 1'b0);
        settle();
    endtask

    always @(negedge clk) begin
        logic [71:0] ew;
        logic [4:0]  ec;
        for (int m = 0; m < 3; m++) begin
            if (out_valid[m] === 1'b1 && out_ready[m] === 1'b1) begin
                win_cnt[m]++;
                obs[m][oy[m]][ox[m]]     = win_of(m);
                obs_eof[m][oy[m]][ox[m]] = out_eof[m];
                check("window_expected", (expq[m].size() > 0), 1'b1);
                if (expq[m].size() > 0) begin
                    ew = expq[m].pop_front();
                    ec = expc[m].pop_front();
                    check("window_pixels", win_of(m), ew);
                    check("window_pos_eof", {ox[m], oy[m], out_eof[m]}, ec);
                end
            end
        end
    end

    initial begin
        logic [71:0] snap;
        rst_n   = 1'b0;
        in_data = '0;
        in_sof  = 1'b0;
        for (int m = 0; m < 3; m++) begin
            in_valid[m]  = 1'b0;
            out_ready[m] = 1'b1;
            mx[m] = 0;
            my[m] = 0;
        end
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++)
            check("reset_state",
                  {out_valid[m], out_eof[m], ox[m], oy[m], win_of(m)}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) check("ready_after_reset", in_ready[m], 1'b1);

        // Scenario 1: interior-only windows
        clear_obs();
        run_frame(0);
        check("m0_count", win_cnt[0], 4);
        check("m0_first", obs[0][2][2],
              {8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33});
        check("m0_last", obs[0][3][3],
              {8'h22, 8'h23, 8'h24, 8'h32, 8'h33, 8'h34, 8'h42, 8'h43, 8'h44});
        check("m0_eof_last", obs_eof[0][3][3], 1'b1);
        check("m0_eof_first", obs_eof[0][2][2], 1'b0);

        // Scenario 2: zero padding
        clear_obs();
        run_frame(1);
        check("m1_count", win_cnt[1], 16);
        check("m1_origin", obs[1][0][0], 72'h11);
        check("m1_11", obs[1][1][1],
              {8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h12, 8'h00, 8'h21, 8'h22});

        // Scenario 3: edge replication
        clear_obs();
        run_frame(2);
        check("m2_count", win_cnt[2], 16);
        check("m2_origin", obs[2][0][0], {9{8'h11}});
        check("m2_10", obs[2][0][1], {3{8'h11, 8'h11, 8'h12}});
        check("m2_02", obs[2][2][0],
              {8'h11, 8'h11, 8'h11, 8'h21, 8'h21, 8'h21, 8'h31, 8'h31, 8'h31});

        // Scenario 4: downstream stall holds the window
        clear_obs();
        for (int i = 0; i < 5; i++) drive(1, pix(i), 1'b0, 1'b0);
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        in_data      = pix(5);
        snap = win_of(1);
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", in_ready[1], 1'b0);
            check("stall_hold", win_of(1), snap);
            @(posedge clk);
            #1;
        end
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b0;
        for (int i = 5; i < W * H; i++) drive(1, pix(i), 1'b0, 1'b0);
        settle();
        check("stall_count", win_cnt[1], 16);
        check("stall_11", obs[1][1][1],
              {8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h12, 8'h00, 8'h21, 8'h22});

        // Scenario 5: in_sof restarts the frame mid-stream
        clear_obs();
        for (int i = 0; i < 5; i++) drive(1, pix(i), 1'b0, 1'b0);
        drive(1, 8'hA5, 1'b1, 1'b0);
        check("sof_pos", {ox[1], oy[1]}, 4'h0);
        check("sof_win", win_of(1), 72'hA5);
        for (int i = 1; i < W * H; i++) drive(1, pix(i), 1'b0, 1'b0);
        settle();
        check("sof_count", win_cnt[1], 21);
        check("sof_11", obs[1][1][1],
              {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h12, 8'h00, 8'h21, 8'h22});
        check("sof_eof", obs_eof[1][3][3], 1'b1);

        // Scenario 6: reset mid-frame
        for (int i = 0; i < 7; i++) drive(1, pix(i), 1'b0, 1'b0);
        rst_n = 1'b0;
        for (int m = 0; m < 3; m++) begin
            mx[m] = 0;
            my[m] = 0;
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++)
            check("midreset_state",
                  {out_valid[m], out_eof[m], ox[m], oy[m], win_of(m)}, '0);
        check("midreset_drained", expq[1].size(), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_ready", in_ready[1], 1'b1);
        clear_obs();
        run_frame(1);
        check("rerun_count", win_cnt[1], 16);
        check("rerun_origin", obs[1][0][0], 72'h11);
        check("rerun_11", obs[1][1][1],
              {8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h12, 8'h00, 8'h21, 8'h22});

        // Random data, gaps, backpressure and occasional in_sof
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 2 * W * H; i++)
                drive(m, 8'($urandom), ($urandom_range(0, 40) == 0), 1'b1);
            out_ready[m] = 1'b1;
            settle();
        end
        repeat (4) @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) check("all_delivered", expq[m].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
